register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 133 +++++++++++++
 tb/tb_register_file.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with rename tracking: 32 x 32-bit values plus a
// busy bit and reorder-buffer tag per register, and two combinational query ports.
// Define WB_BYPASS_EN to let queries see a matching same-cycle writeback.

module register_file_query #(
    parameter int TAG_W = 5
) (
    input  logic [4:0]             regid,
    input  logic [31:0][31:0]      values,
    input  logic [31:0]            busy,
    input  logic [31:0][TAG_W-1:0] tags,
    output logic                   q_busy,
    output logic [TAG_W-1:0]       q_tag,
    output logic [31:0]            q_val
);
    always_comb begin
        q_busy = busy[regid];
        q_tag  = busy[regid] ? tags[regid] : '0;
        q_val  = busy[regid] ? 32'd0 : values[regid];
    end
endmodule

module register_file #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hci_rdy,
    input  logic             flush,
    input  logic             rename_en,
    input  logic [4:0]       rename_regid,
    input  logic [TAG_W-1:0] rename_tag,
    input  logic             wb_en,
    input  logic [4:0]       wb_regid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_val,
    input  logic [4:0]       query_regid1,
    input  logic [4:0]       query_regid2,
    output logic             query_busy1,
    output logic             query_busy2,
    output logic [TAG_W-1:0] query_tag1,
    output logic [TAG_W-1:0] query_tag2,
    output logic [31:0]      query_val1,
    output logic [31:0]      query_val2
);
    localparam int NUM_PORTS = 2;

    logic [31:0][31:0]      values;
    logic [31:0]            busy;
    logic [31:0][TAG_W-1:0] tags;

    logic [31:0] wb_hit, ren_hit, wb_clear;
    logic [31:0]            eff_busy;
    logic [31:0][31:0]      eff_values;

    // Register x0 is excluded from every hit vector, so it stays zero and idle.
    always_comb begin
        wb_hit   = '0;
        ren_hit  = '0;
        wb_clear = '0;
        for (int i = 1; i < 32; i++) begin
            wb_hit[i]   = wb_en && (wb_regid == 5'(i));
            ren_hit[i]  = rename_en && !flush && (rename_regid == 5'(i));
            wb_clear[i] = wb_hit[i] && busy[i] && (tags[i] == wb_tag);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            values <= '0;
            busy   <= '0;
            tags   <= '0;
        end else if (hci_rdy) begin
            for (int i = 0; i < 32; i++) begin
                if (wb_hit[i])
                    values[i] <= wb_val;
                // Rename outranks writeback: a newer producer owns the register.
                if (flush) begin
                    busy[i] <= 1'b0;
                    tags[i] <= '0;
                end else if (ren_hit[i]) begin
                    busy[i] <= 1'b1;
                    tags[i] <= rename_tag;
                end else if (wb_clear[i]) begin
                    busy[i] <= 1'b0;
                    tags[i] <= '0;
                end
            end
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        eff_busy = busy & ~wb_clear;
        for (int i = 0; i < 32; i++)
            eff_values[i] = wb_clear[i] ? wb_val : values[i];
    end
`else
    always_comb begin
        eff_busy   = busy;
        eff_values = values;
    end
`endif

    logic [NUM_PORTS-1:0][4:0]       q_regid;
    logic [NUM_PORTS-1:0]            q_busy;
    logic [NUM_PORTS-1:0][TAG_W-1:0] q_tag;
    logic [NUM_PORTS-1:0][31:0]      q_val;

    assign q_regid = {query_regid2, query_regid1};

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_query
            register_file_query #(.TAG_W(TAG_W)) u_query (
                .regid  (q_regid[p]),
                .values (eff_values),
                .busy   (eff_busy),
                .tags   (tags),
                .q_busy (q_busy[p]),
                .q_tag  (q_tag[p]),
                .q_val  (q_val[p])
            );
        end
    endgenerate

    assign query_busy1 = q_busy[0];
    assign query_busy2 = q_busy[1];
    assign query_tag1  = q_tag[0];
    assign query_tag2  = q_tag[1];
    assign query_val1  = q_val[0];
    assign query_val2  = q_val[1];
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: rename, writeback, flush, x0 and stall cases
// with hand-computed expectations; honours WB_BYPASS_EN if defined.

module tb_register_file;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst, hci_rdy, flush, rename_en, wb_en;
    logic [4:0]       rename_regid, wb_regid, query_regid1, query_regid2;
    logic [TAG_W-1:0] rename_tag, wb_tag;
    logic [31:0]      wb_val;
    logic             query_busy1, query_busy2;
    logic [TAG_W-1:0] query_tag1, query_tag2;
    logic [31:0]      query_val1, query_val2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    register_file #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .hci_rdy(hci_rdy), .flush(flush),
        .rename_en(rename_en), .rename_regid(rename_regid), .rename_tag(rename_tag),
        .wb_en(wb_en), .wb_regid(wb_regid), .wb_tag(wb_tag), .wb_val(wb_val),
        .query_regid1(query_regid1), .query_regid2(query_regid2),
        .query_busy1(query_busy1), .query_busy2(query_busy2),
        .query_tag1(query_tag1), .query_tag2(query_tag2),
        .query_val1(query_val1), .query_val2(query_val2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; hci_rdy = 1'b1; flush = 1'b0;
        rename_en = 1'b0; rename_regid = '0; rename_tag = '0;
        wb_en = 1'b0; wb_regid = '0; wb_tag = '0; wb_val = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rename(input logic [4:0] r, input logic [TAG_W-1:0] t);
        rename_en = 1'b1; rename_regid = r; rename_tag = t;
    endtask

    task automatic wb(input logic [4:0] r, input logic [TAG_W-1:0] t, input logic [31:0] v);
        wb_en = 1'b1; wb_regid = r; wb_tag = t; wb_val = v;
    endtask

    task automatic query(input logic [4:0] r1, input logic [4:0] r2);
        query_regid1 = r1; query_regid2 = r2;
        #1;
    endtask

    initial begin
        idle();
        query_regid1 = '0; query_regid2 = '0;
        rst = 1'b1;
        tick();

        query(5, 0);
        chk("rst_busy1", query_busy1, 0);
        chk("rst_val1",  query_val1,  0);
        chk("rst_busy2", query_busy2, 0);
        chk("rst_val2",  query_val2,  0);
        query(0, 5);
        chk("rst_x0_busy1", query_busy1, 0);
        chk("rst_x0_val1",  query_val1,  0);
        chk("rst_x5_tag2",  query_tag2,  0);

        // rename then matching writeback
        rename(5, 3); tick();
        query(5, 5);
        chk("ren_busy1", query_busy1, 1);
        chk("ren_tag1",  query_tag1,  3);
        chk("ren_val1",  query_val1,  0);
        chk("ren_tag2",  query_tag2,  3);
        wb(5, 3, 32'hDEADBEEF);
        query(5, 5);
`ifdef WB_BYPASS_EN
        chk("byp5_busy", query_busy1, 0);
        chk("byp5_val",  query_val1,  32'hDEADBEEF);
`else
        chk("nobyp5_busy", query_busy1, 1);
        chk("nobyp5_tag",  query_tag1,  3);
`endif
        tick();
        query(5, 5);
        chk("wb_busy1", query_busy1, 0);
        chk("wb_val1",  query_val1,  32'hDEADBEEF);
        chk("wb_tag1",  query_tag1,  0);
        chk("wb_val2",  query_val2,  32'hDEADBEEF);

        // stale writeback against a newer rename
        rename(7, 2); tick();
        rename(7, 9); tick();
        wb(7, 2, 32'h11); tick();
        query(7, 7);
        chk("stale_busy", query_busy1, 1);
        chk("stale_tag",  query_tag1,  9);
        chk("stale_val",  query_val1,  0);
        wb(7, 9, 32'h22); tick();
        query(7, 7);
        chk("fresh_busy", query_busy1, 0);
        chk("fresh_val",  query_val1,  32'h22);

        // same-cycle rename and writeback: value lands, rename wins
        rename(10, 1); tick();
        rename(10, 12); wb(10, 1, 32'h77); tick();
        query(10, 10);
        chk("same_busy", query_busy1, 1);
        chk("same_tag",  query_tag1,  12);
        flush = 1'b1; tick();
        query(10, 10);
        chk("same_flush_busy", query_busy1, 0);
        chk("same_flush_val",  query_val1,  32'h77);

        // flush with concurrent writeback and ignored rename
        wb(2, 0, 32'h2222); tick();
        rename(1, 4); tick();
        rename(2, 5); tick();
        query(1, 2);
        chk("pre_flush_busy1", query_busy1, 1);
        chk("pre_flush_tag2",  query_tag2,  5);
        flush = 1'b1; wb(1, 4, 32'h40); rename(3, 7); tick();
        query(1, 2);
        chk("flush_x1_busy", query_busy1, 0);
        chk("flush_x1_val",  query_val1,  32'h40);
        chk("flush_x2_busy", query_busy2, 0);
        chk("flush_x2_val",  query_val2,  32'h2222);
        query(3, 3);
        chk("flush_x3_busy", query_busy1, 0);

        // x0 writes dropped; stalled cycle changes nothing
        rename(0, 1); wb(0, 0, 32'h55); tick();
        query(0, 0);
        chk("x0_busy", query_busy1, 0);
        chk("x0_val",  query_val1,  0);
        chk("x0_tag",  query_tag2,  0);
        hci_rdy = 1'b0; rename(6, 3); tick();
        hci_rdy = 1'b0; wb(6, 0, 32'h66); tick();
        query(6, 6);
        chk("stall_busy", query_busy1, 0);
        chk("stall_val",  query_val1,  0);

        // writeback visibility in the writeback cycle
        rename(8, 6); tick();
        wb(8, 6, 32'h99);
        query(8, 8);
`ifdef WB_BYPASS_EN
        chk("byp8_busy", query_busy2, 0);
        chk("byp8_tag",  query_tag2,  0);
        chk("byp8_val",  query_val2,  32'h99);
`else
        chk("nobyp8_busy", query_busy2, 1);
        chk("nobyp8_tag",  query_tag2,  6);
        chk("nobyp8_val",  query_val2,  0);
`endif
        tick();
        query(8, 8);
        chk("wb8_busy", query_busy1, 0);
        chk("wb8_val",  query_val1,  32'h99);

        // reset outranks stall and writes
        rename(9, 4); tick();
        rst = 1'b1; hci_rdy = 1'b0; wb(5, 0, 32'h1234); tick();
        query(5, 9);
        chk("rst2_x5_val",  query_val1,  0);
        chk("rst2_x9_busy", query_busy2, 0);
        chk("rst2_x9_tag",  query_tag2,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
